// File: rtl/cordic_seq_pkg.sv
// Shared types for the CORDIC tone sequencer.
//   state_t : controller states
//   seg_t   : one table entry {amplitude, frequency step, dwell}
// The seg_t field widths come from the *_DEF localparams; the top-level
// width parameters must keep these defaults.
package cordic_seq_pkg;
  localparam int AMP_W_DEF   = 4;
  localparam int FREQ_W_DEF  = 4;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [AMP_W_DEF-1:0]   a;
    logic [FREQ_W_DEF-1:0]  w;
    logic [DWELL_W_DEF-1:0] dwell;
  } seg_t;
endpackage

// File: rtl/cordic_tone_sequencer_if.sv
// Control/status bundle of the tone sequencer.
//   master : register/control side (drives cfg_*, loop_en, start, stop)
//   slave  : the sequencer (drives A, W, busy, seg_idx, seg_start, done)
interface cordic_tone_sequencer_if #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16,
  parameter int AMP_W   = 4,
  parameter int FREQ_W  = 4
);
  localparam int IDX_W = $clog2(DEPTH);

  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [AMP_W-1:0]   cfg_a;
  logic [FREQ_W-1:0]  cfg_w;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [IDX_W-1:0]   cfg_last;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic [AMP_W-1:0]   A;
  logic [FREQ_W-1:0]  W;
  logic               busy;
  logic [IDX_W-1:0]   seg_idx;
  logic               seg_start;
  logic               done;

  modport master (output cfg_we, cfg_addr, cfg_a, cfg_w, cfg_dwell, cfg_last,
                         loop_en, start, stop,
                  input  A, W, busy, seg_idx, seg_start, done);
  modport slave  (input  cfg_we, cfg_addr, cfg_a, cfg_w, cfg_dwell, cfg_last,
                         loop_en, start, stop,
                  output A, W, busy, seg_idx, seg_start, done);
endinterface

// File: rtl/cordic_seq_table.sv
// Segment table: DEPTH x seg_t register file, one write port, async read.
//   clk, rst_n : clock, async active-low reset (clears every entry)
//   i_we/i_waddr/i_wdata : write port (gating is done by the caller)
//   i_raddr/o_rdata      : combinational read port
module cordic_seq_table
  import cordic_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  seg_t             i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output seg_t             o_rdata
);
  seg_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cordic_tone_sequencer.sv
// Steps A/W for CORDIC_angle through a programmed list of segments, holding
// each for max(dwell,1) clocks. All outputs are registered.
//   clk, rst_n : clock, async active-low reset
//   bus        : control/status interface (slave side)
module cordic_tone_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int AMP_W   = AMP_W_DEF,
  parameter int FREQ_W  = FREQ_W_DEF,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  cordic_tone_sequencer_if.slave bus
);
  state_t             r_state;
  logic [AMP_W-1:0]   r_a;
  logic [FREQ_W-1:0]  r_w;
  logic               r_busy;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last;
  logic               r_seg_start;
  logic               r_done;
  logic [DWELL_W-1:0] r_cnt;

  logic               w_we;
  logic [IDX_W-1:0]   w_rd_addr;
  seg_t               w_seg;
  seg_t               w_wdata;
  logic [DWELL_W-1:0] w_cnt_ld;
  logic               w_more;

  // Table is frozen while running; start also blocks a same-cycle write.
  assign w_we    = bus.cfg_we & ~r_busy & ~bus.start;
  assign w_wdata = '{a: bus.cfg_a, w: bus.cfg_w, dwell: bus.cfg_dwell};

  // Single read port always looks at the segment that would be loaded next:
  // entry 0 from IDLE or on wrap, otherwise seg_idx+1.
  assign w_rd_addr = (r_state == RUN && r_idx != r_last) ? IDX_W'(r_idx + 1'b1) : '0;
  assign w_cnt_ld  = (w_seg.dwell == '0) ? '0 : w_seg.dwell - 1'b1;
  assign w_more    = (r_idx != r_last) || bus.loop_en;

  cordic_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (bus.cfg_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_w         <= '0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
      r_last      <= '0;
      r_seg_start <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_seg_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_last      <= bus.cfg_last;
            r_idx       <= w_rd_addr;
            r_a         <= w_seg.a;
            r_w         <= w_seg.w;
            r_cnt       <= w_cnt_ld;
            r_seg_start <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop || (r_cnt == '0 && !w_more)) begin
            // abort or normal end; only the normal end reports done
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_a     <= '0;
            r_w     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_done  <= ~bus.stop;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_idx       <= w_rd_addr;
            r_a         <= w_seg.a;
            r_w         <= w_seg.w;
            r_cnt       <= w_cnt_ld;
            r_seg_start <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.A         = r_a;
  assign bus.W         = r_w;
  assign bus.busy      = r_busy;
  assign bus.seg_idx   = r_idx;
  assign bus.seg_start = r_seg_start;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_cordic_tone_sequencer.sv
module tb_cordic_tone_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ntests = 0;
  int nfail = 0;

  cordic_tone_sequencer_if #(.DEPTH(8), .DWELL_W(16), .AMP_W(4), .FREQ_W(4)) bus ();
  cordic_tone_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // reference table and run parameters
  int m_a [8];
  int m_w [8];
  int m_d [8];
  int m_last;

  typedef struct {
    logic [3:0] a, w;
    logic [2:0] idx;
    logic busy, ss, done;
    int pass;
  } exp_t;

  function automatic logic [13:0] obs();
    return {bus.A, bus.W, bus.seg_idx, bus.busy, bus.seg_start, bus.done};
  endfunction

  function automatic logic [13:0] pk(exp_t e);
    return {e.a, e.w, e.idx, e.busy, e.ss, e.done};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin m_a[i] = 0; m_w[i] = 0; m_d[i] = 0; end
  endtask

  task automatic prog(input int idx, input int a, input int w, input int d);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(idx);
    bus.cfg_a = 4'(a); bus.cfg_w = 4'(w); bus.cfg_dwell = 16'(d);
    tick();
    bus.cfg_we = 1'b0;
    m_a[idx] = a; m_w[idx] = w; m_d[idx] = d;
  endtask

  task automatic chk_zero(input string name);
    ntests++;
    if (obs() !== 14'h0) begin
      nfail++;
      $display("FAIL %s: got %h want 0000", name, obs());
    end
  endtask

  // Expected per-cycle stream: every segment held max(dwell,1) clocks, passes
  // repeated, then one done cycle. stop_mode: 0 none, 1 random, else index+2.
  task automatic run_seq(input int passes, input int stop_mode, input bit we_run,
                         input bit we_start, input string name);
    exp_t q[$];
    exp_t e;
    int nbusy;
    int stop_at;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s <= m_last; s++) begin
        int n = (m_d[s] == 0) ? 1 : m_d[s];
        for (int c = 0; c < n; c++) begin
          e.a = 4'(m_a[s]); e.w = 4'(m_w[s]); e.idx = 3'(s);
          e.busy = 1'b1; e.ss = (c == 0); e.done = 1'b0; e.pass = p;
          q.push_back(e);
        end
      end
    nbusy = q.size();
    e.a = 0; e.w = 0; e.idx = 0; e.busy = 0; e.ss = 0; e.done = 1; e.pass = passes;
    q.push_back(e);
    stop_at = -1;
    if (stop_mode == 1) stop_at = $urandom_range(nbusy - 1);
    else if (stop_mode >= 2) stop_at = stop_mode - 2;

    bus.loop_en = (passes > 1);
    bus.cfg_last = 3'(m_last);
    bus.start = 1'b1;
    if (we_start) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_a = 4'd7; bus.cfg_w = 4'd7; bus.cfg_dwell = 16'd9;
    end
    tick();
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_last = 3'($urandom_range(7));  // must not affect the run
    for (int i = 0; i < q.size(); i++) begin
      ntests++;
      if (obs() !== pk(q[i])) begin
        nfail++;
        $display("FAIL %s cyc%0d: got %h want %h", name, i, obs(), pk(q[i]));
      end
      if (passes > 1 && q[i].pass == passes - 1 && (q[i].idx == 1 || m_last == 0))
        bus.loop_en = 1'b0;
      if (i == 1 && q[1].busy) begin
        bus.start = 1'b1;  // ignored while running
        if (we_run) begin
          bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_a = 4'd7; bus.cfg_w = 4'd7;
        end
      end
      if (i == stop_at) begin
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0; bus.cfg_we = 1'b0;
        chk_zero({name, "_stop"});
        return;
      end
      tick();
      bus.start = 1'b0; bus.cfg_we = 1'b0;
    end
    chk_zero({name, "_idle"});
  endtask

  task automatic test_reset();
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_a = 0; bus.cfg_w = 0; bus.cfg_dwell = 0;
    bus.cfg_last = 0; bus.loop_en = 0; bus.start = 0; bus.stop = 0;
    rst_n = 1'b0;
    clear_model();
    tick(); tick();
    chk_zero("reset_held");
    rst_n = 1'b1;
    tick();
    chk_zero("reset_released");
  endtask

  task automatic prog_directed();
    prog(0, 1, 1, 5); prog(1, 2, 2, 3); prog(2, 4, 4, 2);
    m_last = 2;
  endtask

  task automatic test_basic();
    prog_directed();
    run_seq(1, 0, 0, 0, "basic");
  endtask

  task automatic test_loop();
    run_seq(2, 0, 0, 0, "loop2");
    run_seq(3, 0, 0, 0, "loop3");
  endtask

  task automatic test_dwell0();
    prog(0, 3, 5, 0);
    m_last = 0;
    run_seq(1, 0, 0, 0, "dwell0");
  endtask

  task automatic test_stop();
    prog_directed();
    run_seq(1, 6 + 2, 0, 0, "stop_seg1");   // 2nd clock of segment 1
    run_seq(1, 9 + 2, 0, 0, "stop_vs_done"); // stop on the final cycle
    run_seq(1, 0, 0, 0, "restart");
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_zero("start_stop_idle");
  endtask

  task automatic test_write_block();
    prog_directed();
    run_seq(1, 0, 1, 0, "we_in_run");
    run_seq(1, 0, 0, 1, "we_with_start");
  endtask

  task automatic test_async_reset();
    prog_directed();
    bus.cfg_last = 3'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    #3;
    rst_n = 1'b1;
    clear_model();
    tick();
    m_last = 3;
    run_seq(1, 0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 8; i++)
        prog(i, $urandom_range(15), $urandom_range(15), $urandom_range(5));
      m_last = $urandom_range(7);
      run_seq($urandom_range(1, 2), $urandom_range(1), $urandom_range(1), $urandom_range(1),
              $sformatf("rand%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_dwell0();
    test_stop();
    test_write_block();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
